// File: rtl/vga_scanout.sv
// VGA 640x480 timing and VRAM scanout of a windowed grayscale image.
// One pixel per two clk; sync/blank delayed to line up with VRAM data.
module vga_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter logic [31:0] BASE_ENC = 32'h0,
  parameter logic [31:0] BASE_DEC = 32'h10000,
  parameter int          RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        image_select,
  output logic [31:0] gpu_address,
  input  logic [7:0]  vram_out,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb_out,
  output logic        blank_n,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DEPTH   = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [31:0] H_VIS   = 32'(H_ACTIVE);
  localparam logic [31:0] V_VIS   = 32'(V_ACTIVE);
  localparam logic [31:0] HS_ON   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_OFF  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_ON   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_OFF  = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] IX0     = 32'(IMG_X0);
  localparam logic [31:0] IX1     = 32'(IMG_X0 + IMG_W);
  localparam logic [31:0] IY0     = 32'(IMG_Y0);
  localparam logic [31:0] IY1     = 32'(IMG_Y0 + IMG_H);
  localparam logic [31:0] IW      = 32'(IMG_W);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic img;
  } tap_t;

  localparam tap_t TAP_IDLE = '{
    hs:  1'b1,
    vs:  1'b1,
    vis: 1'b0,
    img: 1'b0
  };

  logic          phase_q, phase_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic          fdone_q, fdone_d;
  tap_t          pipe_q [DEPTH];
  tap_t          pipe_d [DEPTH];

  logic          tick;
  logic          frame_start;
  logic          frame_end;
  logic [31:0]   h_w;
  logic [31:0]   v_w;
  logic [31:0]   base;
  logic [31:0]   pix_addr;
  tap_t          raw;

  assign tick        = phase_q;
  assign h_w         = 32'(h_cnt_q);
  assign v_w         = 32'(v_cnt_q);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_end   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign base        = sel_q ? BASE_DEC : BASE_ENC;

  // Phase toggle and raster counters; counters move only on tick
  always_comb begin
    phase_d = ~phase_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Undelayed sync, visible and image-window flags of the current pixel
  always_comb begin
    raw     = TAP_IDLE;
    raw.hs  = !((h_w >= HS_ON) && (h_w < HS_OFF));
    raw.vs  = !((v_w >= VS_ON) && (v_w < VS_OFF));
    raw.vis = (h_w < H_VIS) && (v_w < V_VIS);
    raw.img = (h_w >= IX0) && (h_w < IX1) &&
              (v_w >= IY0) && (v_w < IY1);
  end

  // VRAM address of the current pixel, held outside the window
  always_comb begin
    pix_addr = base + (v_w - IY0) * IW + (h_w - IX0);
    addr_d   = addr_q;
    if (tick && raw.img) begin
      addr_d = pix_addr;
    end
  end

  // Image choice is frozen for a whole frame at its first pixel
  always_comb begin
    sel_d = sel_q;
    if (tick && frame_start) begin
      sel_d = image_select;
    end
  end

  // One-clk end-of-frame strobe
  always_comb begin
    fdone_d = tick && frame_end;
  end

  // Delay line so flags meet the returning VRAM byte
  always_comb begin
    pipe_d[0] = raw;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      sel_q   <= 1'b0;
      addr_q  <= BASE_ENC;
      fdone_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= TAP_IDLE;
      end
    end else begin
      phase_q <= phase_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      fdone_q <= fdone_d;
      pipe_q  <= pipe_d;
    end
  end

  assign gpu_address = addr_q;
  assign hsync       = pipe_q[DEPTH-1].hs;
  assign vsync       = pipe_q[DEPTH-1].vs;
  assign blank_n     = pipe_q[DEPTH-1].vis;
  assign frame_done  = fdone_q;
  assign rgb_out     = pipe_q[DEPTH-1].img ?
                       {vram_out, vram_out, vram_out} : 24'h0;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (24x17 pixels, 8x6 window).
// Reference derives every output from the clk count since reset release.
module tb_vga_scanout;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 12;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int IMG_W    = 8;
  localparam int IMG_H    = 6;
  localparam int IMG_X0   = 4;
  localparam int IMG_Y0   = 3;
  localparam int RD_LAT   = 2;
  localparam logic [31:0] BASE_ENC = 32'h0;
  localparam logic [31:0] BASE_DEC = 32'h100;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FR = HT * VT;
  localparam int NF = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        image_select = 1'b0;
  logic [31:0] gpu_address;
  logic [7:0]  vram_out;
  logic        hsync;
  logic        vsync;
  logic [23:0] rgb_out;
  logic        blank_n;
  logic        frame_done;

  logic [7:0]  vq [RD_LAT];

  int checks = 0;
  int errors = 0;
  int k = 0;
  bit armed = 1'b0;
  logic frame_sel [NF];

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
    .BASE_ENC(BASE_ENC), .BASE_DEC(BASE_DEC), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .image_select(image_select),
    .gpu_address(gpu_address),
    .vram_out(vram_out),
    .hsync(hsync),
    .vsync(vsync),
    .rgb_out(rgb_out),
    .blank_n(blank_n),
    .frame_done(frame_done)
  );

  // VRAM: returns addr[7:0] RD_LAT clk after the address
  always @(posedge clk) begin
    vq[0] <= gpu_address[7:0];
    for (int i = 1; i < RD_LAT; i++) vq[i] <= vq[i-1];
  end
  assign vram_out = vq[RD_LAT-1];

  // Edge count since reset, and image choice seen at each frame start
  always @(posedge clk) begin
    if (!rst) begin
      k     <= 0;
      armed <= 1'b1;
    end else begin
      k <= k + 1;
      if (k + 1 >= 2 && (k - 1) % (2 * FR) == 0 &&
          (k - 1) / (2 * FR) < NF)
        frame_sel[(k - 1) / (2 * FR)] <= image_select;
    end
  end

  function automatic int ph(int p);
    return p % HT;
  endfunction

  function automatic int pv(int p);
    return (p / HT) % VT;
  endfunction

  function automatic bit in_img(int p);
    return ph(p) >= IMG_X0 && ph(p) < IMG_X0 + IMG_W &&
           pv(p) >= IMG_Y0 && pv(p) < IMG_Y0 + IMG_H;
  endfunction

  function automatic bit vis(int p);
    return ph(p) < H_ACTIVE && pv(p) < V_ACTIVE;
  endfunction

  function automatic bit hs_low(int p);
    return ph(p) >= H_ACTIVE + H_FP && ph(p) < H_ACTIVE + H_FP + H_SYNC;
  endfunction

  function automatic bit vs_low(int p);
    return pv(p) >= V_ACTIVE + V_FP && pv(p) < V_ACTIVE + V_FP + V_SYNC;
  endfunction

  function automatic logic [31:0] pix_addr(int q);
    logic [31:0] b;
    int f;
    f = q / FR;
    b = BASE_ENC;
    if (f < NF) begin
      if (frame_sel[f] === 1'b1) b = BASE_DEC;
    end
    return b + 32'((pv(q) - IMG_Y0) * IMG_W + (ph(q) - IMG_X0));
  endfunction

  // Address of the most recent window pixel already ticked by edge kk
  function automatic logic [31:0] exp_addr(int kk);
    logic [31:0] r;
    bit found;
    r = BASE_ENC;
    found = 1'b0;
    for (int q = kk / 2 - 1; q >= 0 && !found; q--) begin
      if (in_img(q)) begin
        r = pix_addr(q);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ea;
    logic [7:0]  vb;
    bit e_hs, e_vs, e_vis, e_img, e_fd;
    int d;
    e_hs = 1'b1; e_vs = 1'b1; e_vis = 1'b0; e_img = 1'b0; vb = 8'h0;
    if (k >= 3) begin
      d = (k - 3) / 2;
      e_hs  = !hs_low(d);
      e_vs  = !vs_low(d);
      e_vis = vis(d);
      e_img = in_img(d);
      ea = exp_addr(k - 2);
      vb = ea[7:0];
    end
    e_fd = k >= 2 && k % 2 == 0 && ((k / 2 - 1) % FR) == FR - 1;
    chk("m_addr", gpu_address, exp_addr(k));
    chk("m_hsync", 32'(hsync), 32'(e_hs));
    chk("m_vsync", 32'(vsync), 32'(e_vs));
    chk("m_blank_n", 32'(blank_n), 32'(e_vis));
    chk("m_frame_done", 32'(frame_done), 32'(e_fd));
    chk("m_rgb", 32'(rgb_out), e_img ? 32'({vb, vb, vb}) : 32'h0);
  endtask

  task automatic wait_k(input int t);
    int n = 0;
    while (k < t && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_k", 32'(k), 32'(t));
  endtask

  function automatic bit active(int s);
    case (s)
      0:       return hsync === 1'b0;
      1:       return vsync === 1'b0;
      default: return frame_done === 1'b1;
    endcase
  endfunction

  // Active length and period of one signal, in clk
  task automatic measure(input int s, output int len, output int per);
    int n = 0;
    while (active(s) && n < 4000) begin @(negedge clk); n++; end
    while (!active(s) && n < 4000) begin @(negedge clk); n++; end
    len = 0;
    while (active(s) && len < 4000) begin len++; @(negedge clk); end
    per = len;
    while (!active(s) && per < 4000) begin per++; @(negedge clk); end
  endtask

  typedef struct {
    int          h;
    int          v;
    logic        bl;
    logic        hs;
    logic        vs;
    logic [31:0] addr;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    forever begin
      @(negedge clk);
      if (armed) check_outputs();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, len, per, hold;
    for (int i = 0; i < NF; i++) frame_sel[i] = 1'b0;

    tbl[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 32'h00, 24'h000000};
    tbl[1]  = '{4,  3,  1'b1, 1'b1, 1'b1, 32'h00, 24'h000000};
    tbl[2]  = '{11, 3,  1'b1, 1'b1, 1'b1, 32'h07, 24'h070707};
    tbl[3]  = '{12, 3,  1'b1, 1'b1, 1'b1, 32'h07, 24'h000000};
    tbl[4]  = '{19, 3,  1'b0, 1'b0, 1'b1, 32'h07, 24'h000000};
    tbl[5]  = '{2,  4,  1'b1, 1'b1, 1'b1, 32'h07, 24'h000000};
    tbl[6]  = '{5,  4,  1'b1, 1'b1, 1'b1, 32'h09, 24'h090909};
    tbl[7]  = '{11, 8,  1'b1, 1'b1, 1'b1, 32'h2F, 24'h2F2F2F};
    tbl[8]  = '{10, 10, 1'b1, 1'b1, 1'b1, 32'h2F, 24'h000000};
    tbl[9]  = '{20, 13, 1'b0, 1'b0, 1'b0, 32'h2F, 24'h000000};
    tbl[10] = '{0,  14, 1'b0, 1'b1, 1'b0, 32'h2F, 24'h000000};
    tbl[11] = '{23, 16, 1'b0, 1'b1, 1'b1, 32'h2F, 24'h000000};

    repeat (4) @(negedge clk);
    chk("rst_addr", gpu_address, BASE_ENC);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_blank", 32'(blank_n), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      p = tbl[i].v * HT + tbl[i].h;
      wait_k(2 * p + 3);
      chk("tbl_blank_n", 32'(blank_n), 32'(tbl[i].bl));
      chk("tbl_hsync", 32'(hsync), 32'(tbl[i].hs));
      chk("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
      chk("tbl_addr", gpu_address, tbl[i].addr);
      wait_k(2 * p + 4);
      chk("tbl_rgb", 32'(rgb_out), 32'(tbl[i].rgb));
    end

    wait_k(2 * (FR + 6 * HT) + 1);
    image_select = 1'b1;
    wait_k(2 * (FR + 7 * HT + 4) + 3);
    chk("sel_hold_a", gpu_address, 32'h20);
    wait_k(2 * (FR + 8 * HT + 11) + 3);
    chk("sel_hold_b", gpu_address, 32'h2F);
    wait_k(2 * (2 * FR + 3 * HT + 4) + 3);
    chk("sel_new_first", gpu_address, 32'h100);
    wait_k(2 * (2 * FR + 8 * HT + 11) + 3);
    chk("sel_new_last", gpu_address, 32'h12F);
    image_select = 1'b0;
    wait_k(2 * (3 * FR + 3 * HT + 4) + 3);
    chk("sel_back", gpu_address, 32'h0);

    measure(0, len, per);
    chk("hsync_low_clk", 32'(len), 32'(2 * H_SYNC));
    chk("line_clk", 32'(per), 32'(2 * HT));
    measure(1, len, per);
    chk("vsync_low_clk", 32'(len), 32'(2 * HT * V_SYNC));
    chk("vframe_clk", 32'(per), 32'(2 * FR));
    measure(2, len, per);
    chk("fdone_width", 32'(len), 32'h1);
    chk("fdone_period", 32'(per), 32'(2 * FR));

    image_select = 1'b1;
    p = (k / 2) / FR * FR + FR + 10 * HT + 5;
    wait_k(2 * p + 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_addr", gpu_address, BASE_ENC);
    chk("mid_rst_hsync", 32'(hsync), 32'h1);
    chk("mid_rst_vsync", 32'(vsync), 32'h1);
    chk("mid_rst_blank", 32'(blank_n), 32'h0);
    chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
    chk("mid_rst_fdone", 32'(frame_done), 32'h0);
    wait_k(2);
    chk("restart_blank_k2", 32'(blank_n), 32'h0);
    wait_k(3);
    chk("restart_blank_k3", 32'(blank_n), 32'h1);
    wait_k(2 * (3 * HT + 4) + 3);
    chk("restart_dec_first", gpu_address, BASE_DEC);

    hold = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) image_select = ~image_select;
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b1;
      end else if (c == 3000 || $urandom_range(0, 1999) == 0) begin
        rst = 1'b0;
        hold = $urandom_range(1, 3);
      end
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
